// File: rtl/div7_arbiter.sv
// div7_arbiter: round-robin front end that lets N requesters share one
// divide-by-7 unit. One request is in flight at a time.
//
// Handshake sequence for each request:
//   1. IDLE grants a requester and latches its dividend.
//   2. ISSUE starts the divider.
//   3. WAIT collects the divider result, or times out.
//   4. RESP returns a one-cycle response to the granted requester.
//
// All outputs come from registers or from a decode of the state, so no
// input reaches an output combinationally.
module div7_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 300
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  input  logic [16*N-1:0]   req_data,
  output logic [N-1:0]      req_ready,
  output logic [N-1:0]      rsp_valid,
  output logic [13:0]       rsp_q,
  output logic [3:0]        rsp_rem,
  output logic              rsp_err,
  output logic              active,
  output logic [7:0]        err_cnt,
  output logic              div_start,
  output logic [15:0]       div_data,
  input  logic              div_valid,
  input  logic              div_busy,
  input  logic [13:0]       div_q,
  input  logic [3:0]        div_rem
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt;
  logic [WW-1:0] wd;
  logic          grant_found;
  logic [IW-1:0] grant_idx;

  // First set request bit at or above p, wrapping modulo N. Returns
  // {found, index}. The loop runs downward, so the lowest offset from p is
  // assigned last and wins.
  function automatic logic [IW:0] pick(input logic [N-1:0] v,
                                       input logic [IW-1:0] p);
    logic [IW:0] r;
    int          t;
    r = '0;
    for (int k = N - 1; k >= 0; k--) begin
      t = int'(p) + k;
      if (t >= N) t = t - N;
      if (v[IW'(t)]) r = {1'b1, IW'(t)};
    end
    return r;
  endfunction

  // Build a one-hot vector with bit i set.
  function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
    logic [N-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // Round-robin search over the live request vector.
  always_comb begin
    {grant_found, grant_idx} = pick(req_valid, ptr);
  end

  // Pure decode of the state register.
  assign active = (state != S_IDLE);

  // Sequencer:
  //   - grant in IDLE, start in ISSUE, collect or time out in WAIT;
  //   - every pulse output defaults low and is raised for a single cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      gnt       <= '0;
      wd        <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_q     <= '0;
      rsp_rem   <= '0;
      rsp_err   <= 1'b0;
      err_cnt   <= '0;
      div_start <= 1'b0;
      div_data  <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      div_start <= 1'b0;
      case (state)
        S_IDLE: begin
          // A late div_valid or a still-busy divider blocks new grants.
          if (grant_found && !div_busy && !div_valid) begin
            state     <= S_ISSUE;
            req_ready <= onehot(grant_idx);
            div_data  <= req_data[{grant_idx, 4'b0000} +: 16];
            gnt       <= grant_idx;
            if (int'(grant_idx) == N - 1) ptr <= '0;
            else                          ptr <= grant_idx + IW'(1);
          end
        end
        S_ISSUE: begin
          div_start <= 1'b1;
          wd        <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          // A real result takes priority over a timeout in the same cycle.
          if (div_valid) begin
            rsp_q     <= div_q;
            rsp_rem   <= div_rem;
            rsp_err   <= 1'b0;
            rsp_valid <= onehot(gnt);
            state     <= S_RESP;
          end else if (wd == WW'(TIMEOUT)) begin
            rsp_q     <= '0;
            rsp_rem   <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= onehot(gnt);
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            state     <= S_RESP;
          end else begin
            wd <= wd + WW'(1);
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div7_arbiter.sv
// tb_div7_arbiter: directed bench for div7_arbiter with a behavioural
// divide-by-7 unit of fixed latency that can be told never to answer.
module tb_div7_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 300;
  localparam int LAT     = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [16*N-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [13:0]     rsp_q;
  logic [3:0]      rsp_rem;
  logic            rsp_err;
  logic            active;
  logic [7:0]      err_cnt;
  logic            div_start;
  logic [15:0]     div_data;
  logic            div_valid;
  logic            div_busy;
  logic [13:0]     div_q;
  logic [3:0]      div_rem;
  logic            hang = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div7_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_q(rsp_q),
    .rsp_rem(rsp_rem), .rsp_err(rsp_err), .active(active),
    .err_cnt(err_cnt), .div_start(div_start), .div_data(div_data),
    .div_valid(div_valid), .div_busy(div_busy), .div_q(div_q),
    .div_rem(div_rem)
  );

  // Behavioural divider:
  //   - latches the dividend on div_start;
  //   - answers LAT cycles later with a one-cycle valid pulse;
  //   - drives all-ones on q/rem outside the pulse.
  int          dcnt;
  logic [15:0] dlat;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      div_busy  <= 1'b0;
      div_valid <= 1'b0;
      div_q     <= '1;
      div_rem   <= '1;
      dcnt      <= 0;
      dlat      <= '0;
    end else begin
      div_valid <= 1'b0;
      div_q     <= '1;
      div_rem   <= '1;
      if (div_start && !div_busy) begin
        div_busy <= 1'b1;
        dcnt     <= LAT;
        dlat     <= div_data;
      end else if (div_busy) begin
        if (dcnt == 1) begin
          div_busy <= 1'b0;
          if (!hang) begin
            div_valid <= 1'b1;
            div_q     <= 14'(dlat / 16'd7);
            div_rem   <= 4'(dlat % 16'd7);
          end
        end else begin
          dcnt <= dcnt - 1;
        end
      end
    end
  end

  // Cycle counter and event monitor.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          rdy_cnt[N] = '{default: 0};
  int          rsp_cnt[N] = '{default: 0};
  int          start_cnt  = 0;
  int          bad_onehot = 0;
  logic [15:0] start_data = '0;
  int          start_cyc  = 0;
  int          grant_cyc  = 0;
  int          dvalid_cyc = 0;
  int          rsp_cyc    = 0;
  int          grant_q[$];
  int          rsp_idx_q[$];
  int          rsp_qv_q[$];
  int          rsp_rv_q[$];

  always @(negedge clk) begin
    if (req_ready != '0) begin
      if (!$onehot(req_ready)) bad_onehot++;
      grant_cyc = cyc;
      for (int i = 0; i < N; i++)
        if (req_ready[i]) begin rdy_cnt[i]++; grant_q.push_back(i); end
    end
    if (rsp_valid != '0) begin
      if (!$onehot(rsp_valid)) bad_onehot++;
      rsp_cyc = cyc;
      for (int i = 0; i < N; i++)
        if (rsp_valid[i]) begin
          rsp_cnt[i]++;
          rsp_idx_q.push_back(i);
          rsp_qv_q.push_back(int'(rsp_q));
          rsp_rv_q.push_back(int'(rsp_rem));
        end
    end
    if (div_start) begin start_cnt++; start_data = div_data; start_cyc = cyc; end
    if (div_valid) dvalid_cyc = cyc;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(input string tag, output logic [N-1:0] v);
    bit found = 0;
    v = '0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (req_ready != '0) begin v = req_ready; found = 1; break; end
    end
    if (!found) check_eq({tag, "_rdy_timeout"}, 0, 1);
  endtask

  task automatic wait_rsp(input string tag, output logic [N-1:0] v,
                          output logic [13:0] q, output logic [3:0] r,
                          output logic e);
    bit found = 0;
    v = '0; q = '0; r = '0; e = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        v = rsp_valid; q = rsp_q; r = rsp_rem; e = rsp_err; found = 1;
        break;
      end
    end
    if (!found) check_eq({tag, "_rsp_timeout"}, 0, 1);
  endtask

  task automatic do_req(input int i, input int data, input int eq,
                        input int er, input int ee, input string tag);
    logic [N-1:0] v, oh;
    logic [13:0]  q;
    logic [3:0]   r;
    logic         e;
    oh = '0;
    oh[i] = 1'b1;
    @(negedge clk);
    req_data[16*i +: 16] = 16'(data);
    req_valid[i] = 1'b1;
    wait_rdy(tag, v);
    req_valid[i] = 1'b0;
    check_eq({tag, "_ready"}, 32'(v), 32'(oh));
    wait_rsp(tag, v, q, r, e);
    check_eq({tag, "_rsp_valid"}, 32'(v), 32'(oh));
    check_eq({tag, "_q"}, 32'(q), 32'(eq));
    check_eq({tag, "_rem"}, 32'(r), 32'(er));
    check_eq({tag, "_err"}, 32'(e), 32'(ee));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 0);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check_eq({tag, "_rsp_q"}, 32'(rsp_q), 0);
    check_eq({tag, "_rsp_rem"}, 32'(rsp_rem), 0);
    check_eq({tag, "_rsp_err"}, 32'(rsp_err), 0);
    check_eq({tag, "_active"}, 32'(active), 0);
    check_eq({tag, "_err_cnt"}, 32'(err_cnt), 0);
    check_eq({tag, "_div_start"}, 32'(div_start), 0);
    check_eq({tag, "_div_data"}, 32'(div_data), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL global_time_limit: observed 1 expected 0");
    $fatal(1, "time limit");
  end

  initial begin
    int           base0, base1, base_s, base_tot;
    int           n;
    int           fq[4];
    int           fr[4];
    logic [N-1:0] v;
    logic [13:0]  q;
    logic [3:0]   r;
    logic         e;

    fq = '{1, 2, 4, 5};
    fr = '{3, 6, 2, 5};

    // Reset state
    repeat (5) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single request: 700 -> (100, 0)
    base0  = rdy_cnt[0];
    base_s = start_cnt;
    base1  = rsp_cnt[0];
    do_req(0, 700, 100, 0, 0, "single");
    repeat (3) @(negedge clk);
    check_eq("single_ready_count", 32'(rdy_cnt[0] - base0), 1);
    check_eq("single_start_count", 32'(start_cnt - base_s), 1);
    check_eq("single_div_data", 32'(start_data), 700);
    check_eq("single_rsp_count", 32'(rsp_cnt[0] - base1), 1);
    check_eq("single_start_after_grant", 32'(start_cyc - grant_cyc), 1);
    check_eq("single_rsp_after_valid", 32'(rsp_cyc - dvalid_cyc), 1);

    // Round-robin fairness with all four requesting continuously
    pulse_reset();
    grant_q.delete(); rsp_idx_q.delete(); rsp_qv_q.delete(); rsp_rv_q.delete();
    for (int i = 0; i < N; i++) req_data[16*i +: 16] = 16'(10 * (i + 1));
    req_valid = '1;
    n = 0;
    for (int k = 0; k < 400 && n < 8; k++) begin
      @(negedge clk);
      if (req_ready != '0) n++;
    end
    req_valid = '0;
    check_eq("rr_grant_count", 32'(n), 8);
    for (int k = 0; k < 400 && rsp_idx_q.size() < 8; k++) @(negedge clk);
    check_eq("rr_rsp_count", 32'(rsp_idx_q.size()), 8);
    for (int k = 0; k < 8 && k < grant_q.size() && k < rsp_idx_q.size(); k++) begin
      check_eq($sformatf("rr_grant%0d", k), 32'(grant_q[k]), 32'(k % 4));
      check_eq($sformatf("rr_rsp_idx%0d", k), 32'(rsp_idx_q[k]), 32'(k % 4));
      check_eq($sformatf("rr_q%0d", k), 32'(rsp_qv_q[k]), 32'(fq[k % 4]));
      check_eq($sformatf("rr_rem%0d", k), 32'(rsp_rv_q[k]), 32'(fr[k % 4]));
    end

    // Sweep 0..700 on requester 2
    repeat (5) @(negedge clk);
    base_tot = rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3];
    base1    = bad_onehot;
    for (int i = 0; i <= 700; i++)
      do_req(2, i, i / 7, i % 7, 0, $sformatf("sweep%0d", i));
    repeat (5) @(negedge clk);
    check_eq("sweep_rsp_total",
             32'(rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3] - base_tot), 701);
    check_eq("sweep_onehot_violations", 32'(bad_onehot - base1), 0);

    // Timeout: divider never answers
    hang = 1'b1;
    do_req(0, 1234, 0, 0, 1, "timeout");
    repeat (2) @(negedge clk);
    check_eq("timeout_latency", 32'(rsp_cyc - start_cyc), 32'(TIMEOUT + 1));
    check_eq("timeout_err_cnt", 32'(err_cnt), 1);
    hang = 1'b0;
    repeat (5) @(negedge clk);
    do_req(0, 49, 7, 0, 0, "after_timeout");
    check_eq("after_timeout_err_cnt", 32'(err_cnt), 1);

    // Mid-operation reset while in WAIT (ptr is 3 after granting 2)
    repeat (3) @(negedge clk);
    req_data[16*2 +: 16] = 16'd500;
    req_valid[2] = 1'b1;
    wait_rdy("midrst", v);
    req_valid[2] = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("midrst_active_before", 32'(active), 1);
    base_tot = rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3];
    #1 rst = 1'b1;
    #1 check_all_zero("midrst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("midrst_no_rsp",
             32'(rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3] - base_tot), 0);
    req_data[16*1 +: 16] = 16'd14;
    req_data[16*3 +: 16] = 16'd21;
    req_valid = 4'b1010;
    wait_rdy("ptr_first", v);
    req_valid[1] = 1'b0;
    check_eq("ptr_first_grant", 32'(v), 32'(4'b0010));
    wait_rsp("ptr_first", v, q, r, e);
    check_eq("ptr_first_rsp", 32'(v), 32'(4'b0010));
    check_eq("ptr_first_q", 32'(q), 2);
    check_eq("ptr_first_rem", 32'(r), 0);
    wait_rdy("ptr_second", v);
    req_valid[3] = 1'b0;
    check_eq("ptr_second_grant", 32'(v), 32'(4'b1000));
    wait_rsp("ptr_second", v, q, r, e);
    check_eq("ptr_second_rsp", 32'(v), 32'(4'b1000));
    check_eq("ptr_second_q", 32'(q), 3);
    check_eq("ptr_second_rem", 32'(r), 0);

    // Dropped request: requester 1 appears and vanishes during a service
    repeat (3) @(negedge clk);
    base0 = rdy_cnt[1];
    base1 = rsp_cnt[1];
    req_data[15:0] = 16'd63;
    req_valid[0] = 1'b1;
    wait_rdy("drop", v);
    req_valid[0] = 1'b0;
    check_eq("drop_grant0", 32'(v), 32'(4'b0001));
    repeat (2) @(negedge clk);
    req_data[16*1 +: 16] = 16'd77;
    req_valid[1] = 1'b1;
    repeat (2) @(negedge clk);
    req_valid[1] = 1'b0;
    wait_rsp("drop", v, q, r, e);
    check_eq("drop_rsp0", 32'(v), 32'(4'b0001));
    check_eq("drop_q0", 32'(q), 9);
    check_eq("drop_rem0", 32'(r), 0);
    repeat (20) @(negedge clk);
    check_eq("drop_ready1", 32'(rdy_cnt[1] - base0), 0);
    check_eq("drop_rsp1", 32'(rsp_cnt[1] - base1), 0);
    check_eq("final_onehot_violations", 32'(bad_onehot), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div7_arbiter.md
# div7_arbiter

Round-robin scheduler that shares a single `div_7` divide-by-7 unit (16-bit dividend, 14-bit quotient, 4-bit remainder) among `N` independent requesters. It accepts one request at a time, drives the divider's start/data handshake, and waits for the divider's valid pulse. It then routes the quotient and remainder back to the granted requester as a one-cycle response. A watchdog converts a missing divider response into an error response, so one stuck operation cannot hang every requester.

## Interface
- `N`, 4: number of requesters (2..8).
- `TIMEOUT`, 300: maximum cycles in WAIT before an error response is returned.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset. The same `rst` also resets the `div_7` instance.
- `req_valid` in N: per-requester request. Held with `req_data` until that requester's `req_ready` pulse.
- `req_data` in 16*N: dividends; requester i uses bits [16i+15:16i].
- `req_ready` out N: one-hot, one-cycle accept pulse for the granted requester.
- `rsp_valid` out N: one-hot, one-cycle response pulse to the granted requester.
- `rsp_q` out 14: quotient; valid only while any `rsp_valid` bit is high.
- `rsp_rem` out 4: remainder, 0..6; valid only while any `rsp_valid` bit is high.
- `rsp_err` out 1: high with `rsp_valid` when the response is a timeout; `rsp_q` and `rsp_rem` are then 0.
- `active` out 1: high in every state except IDLE.
- `err_cnt` out 8: saturating count of timeouts since reset.
- `div_start` out 1: one-cycle start pulse to the divider.
- `div_data` out 16: dividend to the divider, registered and held stable from the grant until the next grant.
- `div_valid` in 1, `div_busy` in 1, `div_q` in 14, `div_rem` in 4: divider outputs.

## Operation
- Reset values: all outputs are 0, the FSM is in IDLE, the round-robin pointer `ptr` is 0, and the watchdog counter is 0.
- The FSM has four states: IDLE, ISSUE, WAIT and RESP.
- **IDLE → ISSUE:**
  - Transition requires `req_valid != 0`, `div_busy == 0` and `div_valid == 0`.
  - The arbiter grants the first set `req_valid` bit searching from `ptr` upward, wrapping modulo N.
  - In the same cycle it pulses `req_ready[g]`, registers `div_data <= req_data[g]`, stores `g`, and sets `ptr <= (g+1) mod N`.
- **ISSUE → WAIT:** `div_start` = 1 for exactly this cycle. The watchdog is cleared.
- **WAIT:**
  - The watchdog increments every cycle.
  - If `div_valid` = 1, capture `div_q` and `div_rem`, then go to RESP with the error flag cleared.
  - Otherwise, if the watchdog has reached TIMEOUT, capture 0/0, set the error flag, increment `err_cnt` (saturating at 255), then go to RESP.
  - `div_valid` takes priority over timeout when both occur in the same cycle.
- **RESP → IDLE:** `rsp_valid[g]` = 1 for one cycle, with the registered `rsp_q`, `rsp_rem` and `rsp_err`.
- Dropping a request:
  - A requester may drop `req_valid` before it is granted; it is then simply never granted.
  - `req_valid` is not sampled outside IDLE.
- A `div_valid` that arrives outside WAIT is ignored, for example a late response after a timeout. IDLE will not grant until `div_valid` and `div_busy` are both low.
- Mid-operation reset: every state, output, `ptr` and `err_cnt` returns to its reset value immediately. No response is generated for the aborted request.

## Timing
- Grant is in cycle C0 (`req_ready` high); `div_start` is high in C1.
- If the divider raises `div_valid` in cycle Ck, `rsp_valid` is high in Ck+1.
- Fixed overhead beyond the divider's own latency: 2 cycles at the front (grant and issue) and 1 cycle at the back (response).
- The earliest next grant is the cycle after RESP, provided `div_busy` and `div_valid` are both low.
- A timeout response appears TIMEOUT+1 cycles after ISSUE.
- With N requesters continuously requesting, each one is served exactly once per N consecutive grants.
- Combinational paths from inputs to outputs are forbidden. Every output is driven from a register or decoded from the state.

## Test plan
- **Single request:** reset for 5 cycles, then requester 0 issues `req_data` = 700.
  - `req_ready[0]` pulses once.
  - `div_start` pulses once with `div_data` = 700.
  - `rsp_valid[0]` pulses once with q = 100, rem = 0, err = 0.
- **Round-robin fairness:** N = 4, all requesters continuously request dividends 10, 20, 30, 40.
  - The grant order is 0, 1, 2, 3, 0, and so on.
  - Responses are (1,3), (2,6), (4,2) and (5,5), each on its own `rsp_valid` bit.
- **Sweep:** requester 2 issues dividends 0..700 back to back. Every response must equal (i/7, i%7), and `rsp_valid` must be one-hot with no extra pulses.
- **Timeout:** the divider model never asserts `div_valid`.
  - `rsp_valid` plus `rsp_err` = 1 with q = rem = 0 arrives 301 cycles after `div_start`, and `err_cnt` becomes 1.
  - A later normal request for 49 returns (7,0).
- **Mid-operation reset:** assert `rst` while in WAIT.
  - All outputs are 0 and `active` = 0 immediately, and no `rsp_valid` pulse occurs.
  - After release, a request from requester 3 is granted first only if requesters 0..2 are idle, because `ptr` is back at 0.
- **Dropped request:** requester 1 raises and then drops `req_valid` while requester 0 is being served. Requester 1 never receives `req_ready` or `rsp_valid`.
